// File: rtl/cascada_ab.sv
// High-nibble stage of a cascaded 8-bit counter: tracks the upper nibble from the low stage's carry.
// Optional saturating wrap-event counter enabled by defining CASCADA_WRAP_COUNT_EN.
module cascada_ab (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [1:0] modo,
  input  logic [7:0] D,
  input  logic [3:0] Q_lo,
  input  logic       rco_lo,
  output logic [7:0] Q,
  output logic       rco,
  output logic [1:0] estado,
  output logic [3:0] wraps
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    LOAD  = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t     state;
  logic [3:0] hi;
  logic       load;
  logic       step;
  logic       at_end;
  logic       unused_d;

  assign unused_d = ^D[3:0];

  always_comb begin
    load   = enable && (modo == 2'b11);
    // A load on the same edge as a low-nibble carry wins, so no count and no rco.
    step   = (state == COUNT) && enable && rco_lo && !load;
    at_end = (modo == 2'b01) ? (hi == 4'h0) : (hi == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state <= IDLE;
      hi    <= '0;
      rco   <= 1'b0;
    end else begin
      case (state)
        IDLE:    state <= enable ? (load ? LOAD : COUNT) : IDLE;
        COUNT:   state <= !enable ? IDLE : (load ? LOAD : COUNT);
        LOAD:    state <= (enable && !load) ? COUNT : IDLE;
        default: state <= IDLE;
      endcase

      if (load)
        hi <= D[7:4];
      else if (step)
        hi <= (modo == 2'b01) ? hi - 4'd1 : hi + 4'd1;

      rco <= step && at_end;
    end
  end

`ifdef CASCADA_WRAP_COUNT_EN
  // Counts wrap events on the same edge that raises rco, so wraps and rco move together.
  always_ff @(posedge clk) begin
    if (!reset_L)
      wraps <= '0;
    else if (load)
      wraps <= '0;
    else if (step && at_end && (wraps != 4'hF))
      wraps <= wraps + 4'd1;
  end
`else
  assign wraps = '0;
`endif

  assign Q      = {hi, Q_lo};
  assign estado = state;

endmodule

// File: tb/tb_cascada_ab.sv
// Self-checking bench for cascada_ab: directed vector table plus randomized run against a reference model.
module tb_cascada_ab;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enable;
  logic [1:0] modo;
  logic [7:0] D;
  logic [3:0] Q_lo;
  logic       rco_lo;
  logic [7:0] Q;
  logic       rco;
  logic [1:0] estado;
  logic [3:0] wraps;

  cascada_ab dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .modo(modo), .D(D),
    .Q_lo(Q_lo), .rco_lo(rco_lo), .Q(Q), .rco(rco), .estado(estado), .wraps(wraps)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, nibble arithmetic with explicit overflow detection.
  int m_st = 0;
  int m_hi = 0;
  int m_rco = 0;
  int m_wr = 0;

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] modo;
    bit [7:0] d;
    bit [3:0] qlo;
    bit       rlo;
    bit [7:0] q;
    bit       rco;
    bit [1:0] st;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input int md, input int d, input bit rlo);
    int  t;
    int  nst;
    bit  ld;
    bit  cnt;
    if (!rst) begin
      m_st = 0; m_hi = 0; m_rco = 0; m_wr = 0;
    end else begin
      ld  = en && (md == 3);
      cnt = (m_st == 1) && en && rlo && !ld;
      case (m_st)
        0:       nst = en ? (ld ? 2 : 1) : 0;
        1:       nst = !en ? 0 : (ld ? 2 : 1);
        2:       nst = (en && !ld) ? 1 : 0;
        default: nst = 0;
      endcase
      m_rco = 0;
      if (ld) begin
        m_hi = d / 16;
        m_wr = 0;
      end else if (cnt) begin
        t = m_hi + ((md == 1) ? -1 : 1);
        if (t < 0 || t > 15) begin
          m_rco = 1;
          if (m_wr < 15) m_wr++;
        end
        m_hi = (t + 16) % 16;
      end
      m_st = nst;
    end
  endtask

  task automatic drive(input bit rst, input bit en, input bit [1:0] md, input bit [7:0] d,
                       input bit [3:0] qlo, input bit rlo);
    reset_L = rst; enable = en; modo = md; D = d; Q_lo = qlo; rco_lo = rlo;
    @(posedge clk);
    model_step(rst, en, int'(md), int'(d), rlo);
    #1;
  endtask

  int exp_wr;

  initial begin
    reset_L = 1'b0; enable = 1'b0; modo = 2'b00; D = '0; Q_lo = '0; rco_lo = 1'b0;

    tbl = '{
      '{0,1,2'd0,8'h00,4'h3,1, 8'h03,0,2'd0},  // reset overrides enable
      '{0,1,2'd0,8'h00,4'h3,1, 8'h03,0,2'd0},
      '{1,0,2'd0,8'h00,4'h5,0, 8'h05,0,2'd0},
      '{1,1,2'd3,8'hA5,4'h5,0, 8'hA5,0,2'd2},  // load A5
      '{1,1,2'd0,8'h00,4'h6,0, 8'hA6,0,2'd1},
      '{1,1,2'd0,8'h00,4'h0,1, 8'hB0,0,2'd1},
      '{1,0,2'd0,8'h00,4'h0,0, 8'hB0,0,2'd0},
      '{1,1,2'd0,8'h00,4'h0,1, 8'hB0,0,2'd1},  // carry in IDLE ignored
      '{1,1,2'd0,8'h00,4'h0,0, 8'hB0,0,2'd1},  // and not queued
      '{1,1,2'd3,8'hF0,4'h0,0, 8'hF0,0,2'd2},
      '{1,1,2'd0,8'h00,4'hF,0, 8'hFF,0,2'd1},
      '{1,1,2'd0,8'h00,4'h0,1, 8'h00,1,2'd1},  // up-wrap
      '{1,1,2'd0,8'h00,4'h1,0, 8'h01,0,2'd1},
      '{1,1,2'd1,8'h00,4'hF,1, 8'hFF,1,2'd1},  // down-wrap, mode change same edge
      '{1,1,2'd1,8'h00,4'hF,0, 8'hFF,0,2'd1},
      '{1,1,2'd2,8'h00,4'h2,1, 8'h02,1,2'd1},  // mode 10 wraps at F too
      '{1,1,2'd2,8'h00,4'h2,1, 8'h12,0,2'd1},
      '{1,1,2'd1,8'h00,4'h0,1, 8'h00,0,2'd1},
      '{1,1,2'd1,8'h00,4'h0,1, 8'hF0,1,2'd1},
      '{1,1,2'd3,8'h3C,4'hC,1, 8'h3C,0,2'd2},  // collision: load wins
      '{1,1,2'd3,8'h70,4'h0,0, 8'h70,0,2'd0},  // LOAD with modo=11 -> IDLE
      '{1,1,2'd0,8'h00,4'h0,0, 8'h70,0,2'd1},
      '{0,1,2'd0,8'h00,4'h0,1, 8'h00,0,2'd0},  // reset mid-run with carry
      '{1,0,2'd0,8'h00,4'h0,1, 8'h00,0,2'd0},
      '{1,1,2'd0,8'h00,4'h0,0, 8'h00,0,2'd1}
    };

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].modo, tbl[i].d, tbl[i].qlo, tbl[i].rlo);
      chk($sformatf("vec%0d_Q", i), int'(Q), int'(tbl[i].q));
      chk($sformatf("vec%0d_rco", i), int'(rco), int'(tbl[i].rco));
      chk($sformatf("vec%0d_estado", i), int'(estado), int'(tbl[i].st));
`ifdef CASCADA_WRAP_COUNT_EN
      exp_wr = m_wr;
`else
      exp_wr = 0;
`endif
      chk($sformatf("vec%0d_wraps", i), int'(wraps), exp_wr);
    end

    drive(0, 0, 2'd0, 8'h00, 4'h0, 0);
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 85),
            2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), ($urandom_range(0, 99) < 40));
      chk("rnd_Q", int'(Q), m_hi * 16 + int'(Q_lo));
      chk("rnd_rco", int'(rco), m_rco);
      chk("rnd_estado", int'(estado), m_st);
`ifdef CASCADA_WRAP_COUNT_EN
      exp_wr = m_wr;
`else
      exp_wr = 0;
`endif
      chk("rnd_wraps", int'(wraps), exp_wr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cascada_ab.md
CASCADA_AB -- requirements
Module: cascada_ab

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset_L, input, 1 bit; reset is synchronous and active-low.
REQ-003 The block SHALL have the port enable, input, 1 bit, the global count enable shared with the low-nibble counter.
REQ-004 The block SHALL have the port modo, input, 2 bits, the mode shared with the low-nibble counter: 00 up by 1, 01 down by 1, 10 up by 3, 11 load.
REQ-005 The block SHALL have the port D, input, 8 bits, the load value; D[3:0] goes to the low counter and D[7:4] is used here.
REQ-006 The block SHALL have the port Q_lo, input, 4 bits, the low-nibble count from the upstream counter.
REQ-007 The block SHALL have the port rco_lo, input, 1 bit, the low-nibble ripple carry-out, one-cycle pulse.
REQ-008 The block SHALL have the port Q, output, 8 bits, equal to {hi, Q_lo}.
REQ-009 The block SHALL have the port rco, output, 8 bits wide no: 1 bit, the registered 8-bit terminal-count pulse.
REQ-010 The block SHALL have the port estado, output, 2 bits, the current FSM state.
REQ-011 The block SHALL have the port wraps, output, 4 bits, the saturating count of 8-bit wrap events (see Configuration).

Function
REQ-012 hi SHALL be an internal 4-bit register, and Q SHALL be combinational {hi, Q_lo}.
REQ-013 The FSM states SHALL be IDLE=00, COUNT=01 and LOAD=10; 11 is illegal and SHALL go to IDLE the next cycle.
REQ-014 From IDLE: enable=1 with modo=11 SHALL go to LOAD; enable=1 with any other modo SHALL go to COUNT; enable=0 SHALL stay in IDLE.
REQ-015 From COUNT: enable=0 SHALL go to IDLE; modo=11 SHALL go to LOAD; otherwise the FSM SHALL stay in COUNT.
REQ-016 LOAD SHALL last exactly one cycle, then go to COUNT if enable=1 and modo!=11, else to IDLE.
REQ-017 On the edge where enable=1 and modo=11, hi SHALL load D[7:4], independent of state.
REQ-018 In COUNT with enable=1 and rco_lo=1:
- modes 00 and 10: hi SHALL become hi+1 mod 16.
- mode 01: hi SHALL become hi-1 mod 16.
REQ-019 hi SHALL hold whenever rco_lo=0, enable=0, or the state is IDLE or LOAD.
REQ-020 rco SHALL be registered and SHALL be 1 for exactly the cycle after an edge where the FSM was in COUNT, enable=1, rco_lo=1, and either hi=F with modo in {00,10}, or hi=0 with modo=01.
REQ-021 Load SHALL have priority over counting when modo=11 and rco_lo=1 coincide; in that case hi SHALL take D[7:4] and rco SHALL stay 0.
REQ-022 A change of modo during COUNT SHALL take effect on the same edge, with no extra latency.
REQ-023 rco_lo pulses while the FSM is in IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-024 While reset_L=0 at a rising edge: hi SHALL be 0, the state SHALL be IDLE, rco SHALL be 0 and wraps SHALL be 0; reset SHALL override enable and modo.
REQ-025 Reset asserted mid-COUNT SHALL discard any pending rco; the first count SHALL need a new enable after reset_L=1.

Configuration
REQ-026 With macro CASCADA_WRAP_COUNT_EN defined, wraps SHALL increment on each rco=1 cycle and SHALL saturate at F; it SHALL clear only on reset or on a load.
REQ-027 With CASCADA_WRAP_COUNT_EN undefined, wraps SHALL be tied to 0 and no counter register SHALL be synthesized.

Verification
REQ-028 Reset check: drive reset_L=0 for 2 cycles, then 1 -> Q=={4'h0,Q_lo}, rco=0, estado=00, wraps=0.
REQ-029 Load check: enable=1, modo=11, D=8'hA5 -> next cycle hi=A and estado=10; the cycle after, estado=01 if modo changes to 00.
REQ-030 Up-wrap check: hi=F, modo=00, enable=1, rco_lo pulse -> hi=0 and rco=1 for exactly one cycle; wraps=1 when CASCADA_WRAP_COUNT_EN is defined.
REQ-031 Down-wrap check: hi=0, modo=01, rco_lo pulse -> hi=F and rco=1 one cycle later.
REQ-032 Collision check: modo=11, D=8'h3C and rco_lo=1 on the same edge with hi=F -> hi=3, rco=0.
REQ-033 Reset mid-run check: in COUNT with hi=7, pulse reset_L=0 on the same edge as rco_lo=1 -> hi=0, rco=0, estado=00.
